// File: rtl/dmem_arbiter_if.sv
// Data-memory sharing bundle: core MEM-stage port, ext burst port, datamemory port.
// Latency: n/a (signal bundle only).
// Backpressure: core via core_stall, ext via ext_gnt/ext_beat.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 3
);
    logic                  core_req;
    logic                  core_we;
    logic [DM_ADDRESS-1:0] core_addr;
    logic [DATA_W-1:0]     core_wdata;
    logic [2:0]            core_funct3;
    logic                  core_stall;
    logic [DATA_W-1:0]     core_rdata;

    logic                  ext_req;
    logic                  ext_we;
    logic [DM_ADDRESS-1:0] ext_addr;
    logic [LEN_W-1:0]      ext_len;
    logic [DATA_W-1:0]     ext_wdata;
    logic                  ext_gnt;
    logic                  ext_beat;
    logic [DATA_W-1:0]     ext_rdata;
    logic                  ext_rvalid;
    logic                  ext_done;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rdata;

    // Requesters and the memory model sit on the master side.
    modport master (
        output core_req, core_we, core_addr, core_wdata, core_funct3,
        input  core_stall, core_rdata,
        output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
        input  ext_gnt, ext_beat, ext_rdata, ext_rvalid, ext_done,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
        output mem_rdata
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_funct3,
        output core_stall, core_rdata,
        input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
        output ext_gnt, ext_beat, ext_rdata, ext_rvalid, ext_done,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core MEM stage and an ext burst requester.
// Latency: core 0 cycles; ext granted within STARVE_MAX+1 cycles, burst is len+1 back-to-back beats.
// Backpressure: core held via core_stall during ext beats; ext waits for ext_gnt, burst never stalls.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, EXT_BURST} state_t;

    state_t                state, state_nxt;
    logic [SC_W-1:0]       starve_cnt, starve_nxt;
    logic [LEN_W-1:0]      beat_cnt, beat_nxt;
    logic [LEN_W-1:0]      bur_len;
    logic [DM_ADDRESS-1:0] bur_base;
    logic [DM_ADDRESS-1:0] beat_off;
    logic                  bur_we;
    logic                  grant;
    logic                  rd_beat;

    assign grant = (state == IDLE) && bus.ext_req &&
                   (!bus.core_req || (starve_cnt == SC_W'(STARVE_MAX)));
    // Word stride; the add below wraps naturally at the address width.
    assign beat_off       = DM_ADDRESS'({beat_cnt, 2'b00});
    assign bus.core_rdata = bus.mem_rdata;
    assign rd_beat        = bus.ext_beat && bus.mem_rd;

    always_comb begin
        state_nxt      = state;
        starve_nxt     = starve_cnt;
        beat_nxt       = beat_cnt;
        bus.core_stall = 1'b0;
        bus.ext_gnt    = 1'b0;
        bus.ext_beat   = 1'b0;
        bus.ext_done   = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_funct3 = 3'b000;
        // Outputs stay quiet for the whole time reset is held, not just after the edge.
        if (reset) begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        bus.ext_gnt    = 1'b1;
                        bus.ext_beat   = 1'b1;
                        bus.core_stall = bus.core_req;
                        bus.mem_rd     = !bus.ext_we;
                        bus.mem_wr     = bus.ext_we;
                        bus.mem_addr   = bus.ext_addr;
                        bus.mem_wdata  = bus.ext_wdata;
                        bus.mem_funct3 = 3'b010;
                        starve_nxt     = '0;
                        beat_nxt       = LEN_W'(1);
                        if (bus.ext_len == '0) begin
                            bus.ext_done = 1'b1;
                        end else begin
                            state_nxt = EXT_BURST;
                        end
                    end else begin
                        bus.mem_rd     = bus.core_req && !bus.core_we;
                        bus.mem_wr     = bus.core_req && bus.core_we;
                        bus.mem_addr   = bus.core_addr;
                        bus.mem_wdata  = bus.core_wdata;
                        bus.mem_funct3 = bus.core_funct3;
                        if (bus.ext_req && bus.core_req) begin
                            if (starve_cnt != SC_W'(STARVE_MAX)) begin
                                starve_nxt = starve_cnt + SC_W'(1);
                            end
                        end else begin
                            starve_nxt = '0;
                        end
                    end
                end
                EXT_BURST: begin
                    bus.ext_beat   = 1'b1;
                    bus.core_stall = bus.core_req;
                    bus.mem_rd     = !bur_we;
                    bus.mem_wr     = bur_we;
                    bus.mem_addr   = bur_base + beat_off;
                    bus.mem_wdata  = bus.ext_wdata;
                    bus.mem_funct3 = 3'b010;
                    if (beat_cnt == bur_len) begin
                        bus.ext_done = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        beat_nxt = beat_cnt + LEN_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            beat_cnt   <= beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bur_base       <= '0;
            bur_we         <= 1'b0;
            bur_len        <= '0;
            bus.ext_rdata  <= '0;
            bus.ext_rvalid <= 1'b0;
        end else begin
            if (grant) begin
                bur_base <= bus.ext_addr;
                bur_we   <= bus.ext_we;
                bur_len  <= bus.ext_len;
            end
            bus.ext_rvalid <= rd_beat;
            if (rd_beat) begin
                bus.ext_rdata <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a queue-based reference model.
module tb_dmem_arbiter;
    localparam int STARVE = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32), .LEN_W(3)) bus ();

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .LEN_W(3), .STARVE_MAX(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [8:0] a);
        return {7'h5a, a, ~a, a[6:0]};
    endfunction

    assign bus.mem_rdata = memf(bus.mem_addr);

    // Reference model state: addresses of beats still owed by the current burst.
    logic [8:0]  q_addr[$];
    logic        q_we;
    int          wait_cnt;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        seen_gnt;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        wait_cnt = 0;
        exp_rv   = 1'b0;
        exp_rd   = '0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic run_cycle();
        logic       beat, gnt, done, rd, wr, stall;
        logic [8:0] a;
        logic [2:0] f3;
        logic [31:0] wd;
        beat = 0; gnt = 0; done = 0; rd = 0; wr = 0; stall = 0;
        a = '0; f3 = '0; wd = '0;
        #1;
        if (q_addr.size() > 0) begin
            beat = 1; a = q_addr[0]; rd = !q_we; wr = q_we;
            done = (q_addr.size() == 1); stall = bus.core_req; f3 = 3'b010; wd = bus.ext_wdata;
        end else if (bus.ext_req && (!bus.core_req || wait_cnt == STARVE)) begin
            gnt = 1; beat = 1; a = bus.ext_addr; rd = !bus.ext_we; wr = bus.ext_we;
            done = (bus.ext_len == 0); stall = bus.core_req; f3 = 3'b010; wd = bus.ext_wdata;
        end else begin
            rd = bus.core_req && !bus.core_we; wr = bus.core_req && bus.core_we;
            a = bus.core_addr; f3 = bus.core_funct3; wd = bus.core_wdata;
        end
        seen_gnt = bus.ext_gnt;
        chk_val("ext_gnt", 32'(bus.ext_gnt), 32'(gnt));
        chk_val("ext_beat", 32'(bus.ext_beat), 32'(beat));
        chk_val("ext_done", 32'(bus.ext_done), 32'(done));
        chk_val("core_stall", 32'(bus.core_stall), 32'(stall));
        chk_val("mem_rd", 32'(bus.mem_rd), 32'(rd));
        chk_val("mem_wr", 32'(bus.mem_wr), 32'(wr));
        if (rd || wr) begin
            chk_val("mem_addr", 32'(bus.mem_addr), 32'(a));
            chk_val("mem_funct3", 32'(bus.mem_funct3), 32'(f3));
            chk_val("core_rdata", bus.core_rdata, memf(a));
        end
        if (wr) chk_val("mem_wdata", bus.mem_wdata, wd);
        chk_val("ext_rvalid", 32'(bus.ext_rvalid), 32'(exp_rv));
        if (exp_rv) chk_val("ext_rdata", bus.ext_rdata, exp_rd);
        @(posedge clk);
        exp_rv = beat && rd;
        if (exp_rv) exp_rd = memf(a);
        if (q_addr.size() > 0) begin
            void'(q_addr.pop_front());
        end else if (gnt) begin
            q_we = bus.ext_we;
            for (int i = 1; i <= int'(bus.ext_len); i++)
                q_addr.push_back(9'((int'(bus.ext_addr) + 4 * i) % 512));
            wait_cnt = 0;
        end else begin
            wait_cnt = (bus.ext_req && bus.core_req) ? ((wait_cnt < STARVE) ? wait_cnt + 1 : STARVE) : 0;
        end
        @(negedge clk);
    endtask

    task automatic chk_all_quiet(input string tag);
        chk_val({tag, "_mem_rd"}, 32'(bus.mem_rd), 0);
        chk_val({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
        chk_val({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk_val({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk_val({tag, "_mem_funct3"}, 32'(bus.mem_funct3), 0);
        chk_val({tag, "_core_stall"}, 32'(bus.core_stall), 0);
        chk_val({tag, "_ext_gnt"}, 32'(bus.ext_gnt), 0);
        chk_val({tag, "_ext_beat"}, 32'(bus.ext_beat), 0);
        chk_val({tag, "_ext_done"}, 32'(bus.ext_done), 0);
        chk_val({tag, "_ext_rvalid"}, 32'(bus.ext_rvalid), 0);
        chk_val({tag, "_ext_rdata"}, bus.ext_rdata, 0);
    endtask

    task automatic set_core(input logic req, input logic we, input logic [8:0] addr);
        bus.core_req    = req;
        bus.core_we     = we;
        bus.core_addr   = addr;
        bus.core_wdata  = $urandom;
        bus.core_funct3 = 3'($urandom_range(0, 5));
    endtask

    task automatic set_ext(input logic req, input logic we, input logic [8:0] addr, input logic [2:0] len);
        bus.ext_req   = req;
        bus.ext_we    = we;
        bus.ext_addr  = addr;
        bus.ext_len   = len;
        bus.ext_wdata = $urandom;
    endtask

    initial begin
        int gnt_at;
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset = 1'b0;
        set_core(1'b1, 1'b1, 9'h010);
        set_ext(1'b1, 1'b0, 9'h020, 3'd2);
        #3;
        chk_all_quiet("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Core load with no ext traffic.
        set_ext(1'b0, 1'b0, 9'h000, 3'd0);
        set_core(1'b1, 1'b0, 9'h010);
        run_cycle();

        // Ext write burst of four beats while core is idle; ext inputs churn mid-burst.
        set_core(1'b0, 1'b0, 9'h000);
        set_ext(1'b1, 1'b1, 9'h020, 3'd3);
        run_cycle();
        chk_val("burst_gnt_seen", 32'(seen_gnt), 1);
        for (int i = 1; i < 4; i++) begin
            set_ext(1'($urandom), 1'b0, 9'($urandom), 3'($urandom));
            run_cycle();
        end
        set_ext(1'b0, 1'b0, 9'h000, 3'd0);
        run_cycle();

        // Starvation: core busy every cycle, ext held.
        set_core(1'b1, 1'b0, 9'h100);
        run_cycle();
        gnt_at = 0;
        for (int i = 1; i <= 10 && gnt_at == 0; i++) begin
            set_core(1'b1, 1'($urandom), 9'($urandom));
            set_ext(1'b1, 1'b0, 9'h080, 3'd1);
            run_cycle();
            if (seen_gnt) gnt_at = i;
        end
        chk_val("starve_grant_cycle", 32'(gnt_at), 32'(STARVE + 1));
        set_ext(1'b0, 1'b0, 9'h000, 3'd0);
        for (int i = 0; i < 2; i++) begin
            set_core(1'b1, 1'($urandom), 9'($urandom));
            run_cycle();
        end

        // Read burst wrapping past the top of the address space.
        set_core(1'b0, 1'b0, 9'h000);
        set_ext(1'b1, 1'b0, 9'h1FC, 3'd1);
        run_cycle();
        set_ext(1'b0, 1'b0, 9'h000, 3'd0);
        for (int i = 0; i < 3; i++) run_cycle();

        // Reset asserted during beat 1 of a four-beat read burst.
        set_ext(1'b1, 1'b0, 9'h040, 3'd3);
        run_cycle();
        set_ext(1'b0, 1'b0, 9'h000, 3'd0);
        set_core(1'b1, 1'b1, 9'h0A0);
        reset = 1'b0;
        #1;
        chk_all_quiet("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        set_core(1'b1, 1'b0, 9'h0A4);
        run_cycle();
        set_core(1'b0, 1'b0, 9'h000);
        run_cycle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            set_core(($urandom_range(0, 3) != 0), 1'($urandom), 9'($urandom));
            set_ext(($urandom_range(0, 2) == 0), 1'($urandom), 9'($urandom), 3'($urandom));
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
